word_serializer: RTL and testbench
==================================

// Module: word_serializer
// PURPOSE
// Parallel-to-serial front end for the serial sequence-detector path. Accepts WIDTH-bit words
// over a valid/ready handshake and drives them one bit at a time onto the serial line w,
// which feeds the detector's w input directly. One-entry holding buffer allows gap-free streaming.
// PARAMETERS
// WIDTH       8  bits per word (>=2)
// BIT_CYCLES  1  clocks each bit is held on w (>=1)
// MSB_FIRST   1  1: din[WIDTH-1] sent first; 0: din[0] sent first
// IDLE_BIT    0  value driven on w when no word is in flight
// PORTS
// Clk         in   1      single clock, all logic on posedge
// Rst         in   1      synchronous, active-high reset
// din         in   WIDTH  parallel word
// din_valid   in   1      din holds a word
// din_ready   out  1      block can accept; transfer when din_valid & din_ready
// w           out  1      serial bit, registered
// bit_strobe  out  1      high on the first cycle of each bit on w
// word_done   out  1      one-cycle pulse on the final cycle of a word's last bit
// busy        out  1      high while a word is on w or buffered
// BEHAVIOUR
// - Reset (Rst=1 at posedge): state IDLE, buffer empty, counters 0; w=IDLE_BIT,
//   bit_strobe=0, word_done=0, busy=0. din_ready=1 from the first cycle after reset release.
// - din_ready = ~buf_full (registered flag only; never depends on din_valid).
// - States: IDLE (w=IDLE_BIT), SHIFT (w=current bit). Counters: bit_idx 0..WIDTH-1,
//   cyc 0..BIT_CYCLES-1.
// - Load source priority: buffer, then bypass from din. Accepted words go to the buffer
//   unless loaded straight into the shifter in the same cycle.
// - IDLE + accept at cycle N: shifter loaded, SHIFT entered; first bit on w and
//   bit_strobe=1 at cycle N+1 (latency 1).
// - SHIFT: each bit held BIT_CYCLES cycles; bit_strobe=1 only when cyc==0.
//   Final cycle of the last bit: word_done=1; next cycle loads the buffer if full,
//   else din if accepted that cycle (bypass), else returns to IDLE.
// - Back-to-back: with a word available, the next word's first bit follows the previous
//   word's last bit with zero idle cycles.
// - Simultaneous buffer drain and din accept: buffer refills in the same cycle.
//   Accept while full is impossible (din_ready=0).
// - busy = (state==SHIFT) | buf_full.
// - Rst mid-word: shifter and buffer discarded, w=IDLE_BIT next cycle, no word_done pulse.
// - din sampled only on a transfer; din changes while din_ready=0 are ignored.
// STRUCTURE
// - Shared package: state encoding localparams (IDLE, SHIFT), reused by the detector path.
// - Sub-module bit_timer: BIT_CYCLES down-counter emitting bit_start/bit_end. Instantiated
//   once; all else in this module. Counter widths via $clog2, minimum 1.
// TESTING
// T1 reset: Rst high 2 cycles -> w=0, busy=0, word_done=0; din_ready=1 the cycle after release.
// T2 WIDTH=8, BIT_CYCLES=1, MSB_FIRST=1, din=8'b1001_1011 accepted at N -> w=1,0,0,1,1,0,1,1
//    on N+1..N+8; word_done only at N+8; w=0 at N+9.
// T3 two words 8'hA5, 8'h3C, second offered during the first -> 16 contiguous bits
//    1010_0101_0011_1100, no idle cycle; word_done at bits 8 and 16.
// T4 three words offered back-to-back -> din_ready drops after the buffer fills and
//    rises the cycle the buffer drains; no word lost or duplicated.
// T5 BIT_CYCLES=3, MSB_FIRST=0, din=8'h01 -> w=1 for 3 cycles, then 0 for 21;
//    bit_strobe every 3rd cycle.
// T6 Rst asserted at bit 4 of 8'hFF with a buffered word -> w=0 next cycle, busy=0,
//    no word_done; next accepted word serializes from bit 0.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the serial sequence-detector path: state encoding and
// a counter-width helper.
package word_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_serializer_bit_timer.sv
// Per-bit hold timer: a down-counter that marks the first and last cycle of each
// serial bit, plus a one-cycle look-ahead so the parent can register its strobes.
module bit_timer
  import word_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic run_next,
  output logic bit_end,
  output logic bit_start_next,
  output logic bit_end_next
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Count down while a bit is held; reload when a new bit (or word) starts.
  always_comb begin
    cnt_next = RELOAD;
    if (run && run_next && (cnt != {CW{1'b0}})) begin
      cnt_next = cnt - CW'(1);
    end else begin
      cnt_next = RELOAD;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign bit_end        = run && (cnt == {CW{1'b0}});
  assign bit_start_next = run_next && (cnt_next == RELOAD);
  assign bit_end_next   = run_next && (cnt_next == {CW{1'b0}});

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one-entry holding buffer,
// registered serial output w with bit_strobe / word_done markers.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   BIT_CYCLES = 1,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             bit_strobe,
  output logic             word_done,
  output logic             busy
);

  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state, state_next;
  logic             buf_full, buf_full_next;
  logic [WIDTH-1:0] buf_data, buf_data_next;
  logic [WIDTH-1:0] sh, sh_next;
  logic [IW-1:0]    bit_idx, bit_idx_next;
  logic             w_next, strobe_next, done_next;
  logic             accept, bit_end, word_end, slot_free;
  logic             load_buf, load_din, load, advance;
  logic             bit_start_next, bit_end_next;

  // The shifter always sends from its top bit, so LSB-first words are reversed on load.
  function automatic logic [WIDTH-1:0] send_order(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = MSB_FIRST ? d[i] : d[WIDTH-1-i];
    end
    return r;
  endfunction

  assign din_ready = ~buf_full;
  assign busy      = (state == ST_SHIFT) | buf_full;
  assign accept    = din_valid & ~buf_full;
  assign word_end  = (state == ST_SHIFT) & bit_end & (bit_idx == LAST_IDX);
  assign slot_free = (state == ST_IDLE) | word_end;
  assign load_buf  = slot_free & buf_full;
  assign load_din  = slot_free & ~buf_full & accept;
  assign load      = load_buf | load_din;
  assign advance   = (state == ST_SHIFT) & bit_end & ~word_end;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk            (Clk),
    .rst            (Rst),
    .run            (state == ST_SHIFT),
    .run_next       (state_next == ST_SHIFT),
    .bit_end        (bit_end),
    .bit_start_next (bit_start_next),
    .bit_end_next   (bit_end_next)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: stay in SHIFT across word boundaries while a word is available.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load) state_next = ST_SHIFT;
        else      state_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (word_end && !load) state_next = ST_IDLE;
        else                   state_next = ST_SHIFT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Buffer, shifter and output next values.
  always_comb begin
    buf_full_next = buf_full;
    buf_data_next = buf_data;
    sh_next       = sh;
    bit_idx_next  = bit_idx;
    if (load_buf) begin
      buf_full_next = 1'b0;
    end else begin
      buf_full_next = buf_full;
    end
    if (accept && !load_din) begin
      buf_full_next = 1'b1;
      buf_data_next = din;
    end else begin
      buf_data_next = buf_data;
    end
    if (load_buf) begin
      sh_next      = send_order(buf_data);
      bit_idx_next = {IW{1'b0}};
    end else if (load_din) begin
      sh_next      = send_order(din);
      bit_idx_next = {IW{1'b0}};
    end else if (advance) begin
      sh_next      = {sh[WIDTH-2:0], 1'b0};
      bit_idx_next = bit_idx + IW'(1);
    end else if (word_end) begin
      bit_idx_next = {IW{1'b0}};
    end else begin
      bit_idx_next = bit_idx;
    end
    w_next      = (state_next == ST_SHIFT) ? sh_next[WIDTH-1] : IDLE_BIT;
    strobe_next = bit_start_next;
    done_next   = bit_end_next & (bit_idx_next == LAST_IDX);
  end

  // Datapath and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      buf_full   <= 1'b0;
      buf_data   <= {WIDTH{1'b0}};
      sh         <= {WIDTH{1'b0}};
      bit_idx    <= {IW{1'b0}};
      w          <= IDLE_BIT;
      bit_strobe <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      buf_full   <= buf_full_next;
      buf_data   <= buf_data_next;
      sh         <= sh_next;
      bit_idx    <= bit_idx_next;
      w          <= w_next;
      bit_strobe <= strobe_next;
      word_done  <= done_next;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: two instances (1-cycle MSB-first, 3-cycle LSB-first)
// checked against a per-cycle expected-bit queue built from each accepted word.
module tb_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = 8'h00, db = 8'h00;
  logic       ra, wa, sa, doa, ba;
  logic       rb, wb, sb, dob, bb;

  word_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .Clk(clk), .Rst(rst), .din(da), .din_valid(va), .din_ready(ra),
    .w(wa), .bit_strobe(sa), .word_done(doa), .busy(ba)
  );

  word_serializer #(.WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .Clk(clk), .Rst(rst), .din(db), .din_valid(vb), .din_ready(rb),
    .w(wb), .bit_strobe(sb), .word_done(dob), .busy(bb)
  );

  typedef struct packed {
    logic w;
    logic stb;
    logic done;
    logic first;
  } ent_t;

  ent_t       qa[$];
  ent_t       qb[$];
  logic [4:0] exp_a = 5'b00001, exp_b = 5'b00001;  // {w, bit_strobe, word_done, busy, din_ready}
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  int         vectors = 0, miscompares = 0, cyc = 0;

  // Expand an accepted word into the cycles it occupies on the line.
  task automatic push_word(input bit unit_b, input logic [7:0] d);
    int   bc;
    logic bitv;
    ent_t e;
    bc = unit_b ? 3 : 1;
    for (int i = 0; i < 8; i++) begin
      bitv = unit_b ? d[i] : d[7-i];
      for (int c = 0; c < bc; c++) begin
        e.w     = bitv;
        e.stb   = (c == 0);
        e.done  = (i == 7) && (c == bc - 1);
        e.first = (i == 0) && (c == 0);
        if (unit_b) qb.push_back(e);
        else        qa.push_back(e);
      end
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, predict the next cycle.
  task automatic tick(input logic r, input logic v_a, input logic [7:0] d_a,
                      input logic v_b, input logic [7:0] d_b,
                      output logic acc_a, output logic acc_b);
    ent_t e;
    rst = r; va = v_a; da = d_a; vb = v_b; db = d_b;
    acc_a = v_a && rdy_a && !r;
    acc_b = v_b && rdy_b && !r;
    @(posedge clk);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (acc_a) push_word(1'b0, d_a);
      if (acc_b) push_word(1'b1, d_b);
    end
    @(negedge clk);
    cyc++;
    if (qa.size() > 0) begin e = qa.pop_front(); exp_a = {e.w, e.stb, e.done, 1'b1, 1'b1}; end
    else exp_a = 5'b00001;
    if (qb.size() > 0) begin e = qb.pop_front(); exp_b = {e.w, e.stb, e.done, 1'b1, 1'b1}; end
    else exp_b = 5'b00001;
    rdy_a = 1'b1;
    foreach (qa[j]) if (qa[j].first) rdy_a = 1'b0;
    rdy_b = 1'b1;
    foreach (qb[j]) if (qb[j].first) rdy_b = 1'b0;
    exp_a[0] = rdy_a;
    exp_b[0] = rdy_b;
  endtask

  task automatic test_reset();
    logic aa, ab;
    for (int i = 0; i < 3; i++) begin
      tick(i < 2, 1'b0, 8'h00, 1'b0, 8'h00, aa, ab);
      vectors++;
      if ({wa, sa, doa, ba, ra} !== exp_a) begin
        miscompares++;
        $display("FAIL reset_a cyc=%0d got=%b exp=%b", cyc, {wa, sa, doa, ba, ra}, exp_a);
      end
      vectors++;
      if ({wa, doa, ba, ra, wb, dob, bb, rb} !== 8'b0001_0001) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=00010001", cyc, {wa, doa, ba, ra, wb, dob, bb, rb});
      end
    end
  endtask

  task automatic test_single();
    logic aa, ab;
    logic [7:0] got = 8'h00;
    int dones = 0, done_at = -1;
    tick(1'b0, 1'b1, 8'b1001_1011, 1'b0, 8'h00, aa, ab);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, aa, ab);
      vectors++;
      if ({wa, sa, doa, ba, ra} !== exp_a) begin
        miscompares++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {wa, sa, doa, ba, ra}, exp_a);
      end
      if (i < 8) got = {got[6:0], wa};
      if (doa) begin dones++; done_at = i; end
    end
    vectors++;
    if (got !== 8'b1001_1011 || wa !== 1'b0) begin
      miscompares++;
      $display("FAIL single_bits got=%b exp=10011011 trailing_w=%b exp=0", got, wa);
    end
    vectors++;
    if (dones !== 1 || done_at !== 7) begin
      miscompares++;
      $display("FAIL single_done count=%0d at=%0d exp count=1 at=7", dones, done_at);
    end
  endtask

  task automatic test_back_to_back();
    logic aa, ab;
    logic [15:0] got = 16'h0000;
    logic [16:0] dmask = 17'h0;
    tick(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, aa, ab);
    for (int i = 0; i < 17; i++) begin
      if (i > 0) tick(1'b0, i == 1, 8'h3C, 1'b0, 8'h00, aa, ab);
      vectors++;
      if ({wa, sa, doa, ba, ra} !== exp_a) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, {wa, sa, doa, ba, ra}, exp_a);
      end
      if (i < 16) got = {got[14:0], wa};
      dmask[i] = doa;
    end
    vectors++;
    if (got !== 16'hA53C || dmask !== 17'h08080) begin
      miscompares++;
      $display("FAIL b2b_stream bits=%h exp=a53c done_mask=%h exp=08080", got, dmask);
    end
  endtask

  task automatic test_fill();
    logic aa, ab;
    logic [7:0]  words[3];
    logic [23:0] got = 24'h0;
    int idx = 0, nbits = 0, rises = 0;
    logic ra_prev;
    for (int k = 0; k < 3; k++) words[k] = 8'($urandom);
    ra_prev = ra;
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, idx < 3, (idx < 3) ? words[idx] : 8'h00, 1'b0, 8'h00, aa, ab);
      if (aa) idx++;
      vectors++;
      if ({wa, sa, doa, ba, ra} !== exp_a) begin
        miscompares++;
        $display("FAIL fill cyc=%0d got=%b exp=%b", cyc, {wa, sa, doa, ba, ra}, exp_a);
      end
      if (ba) begin got = {got[22:0], wa}; nbits++; end
      if (!ra_prev && ra) rises++;
      ra_prev = ra;
    end
    vectors++;
    if (nbits !== 24 || got !== {words[0], words[1], words[2]} || rises !== 2) begin
      miscompares++;
      $display("FAIL fill_stream bits=%0d data=%h rises=%0d exp bits=24 data=%h rises=2",
               nbits, got, rises, {words[0], words[1], words[2]});
    end
  endtask

  task automatic test_slow();
    logic aa, ab;
    logic eb, es;
    tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, aa, ab);
    for (int i = 0; i < 25; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 8'h00, 1'b0, 8'($urandom), aa, ab);
      vectors++;
      if ({wb, sb, dob, bb, rb} !== exp_b) begin
        miscompares++;
        $display("FAIL slow cyc=%0d got=%b exp=%b", cyc, {wb, sb, dob, bb, rb}, exp_b);
      end
      eb = (i < 3);
      es = (i < 24) && (i % 3 == 0);
      vectors++;
      if (wb !== eb || sb !== es || dob !== (i == 23)) begin
        miscompares++;
        $display("FAIL slow_wave i=%0d w=%b stb=%b done=%b exp %b %b %b", i, wb, sb, dob, eb, es, i == 23);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic aa, ab;
    logic [7:0] got = 8'h00;
    tick(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, aa, ab);
    for (int i = 1; i <= 4; i++) tick(1'b0, i == 1, 8'h5A, 1'b0, 8'h00, aa, ab);
    vectors++;
    if ({wa, ba, ra} !== 3'b110) begin
      miscompares++;
      $display("FAIL mid_before {w,busy,ready}=%b exp=110", {wa, ba, ra});
    end
    for (int i = 0; i < 2; i++) begin
      tick(i == 0, 1'b0, 8'h00, 1'b0, 8'h00, aa, ab);
      vectors++;
      if ({wa, sa, doa, ba, ra} !== 5'b00001 || exp_a !== 5'b00001) begin
        miscompares++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=00001", cyc, {wa, sa, doa, ba, ra});
      end
    end
    tick(1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, aa, ab);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, aa, ab);
      vectors++;
      if ({wa, sa, doa, ba, ra} !== exp_a) begin
        miscompares++;
        $display("FAIL mid_after cyc=%0d got=%b exp=%b", cyc, {wa, sa, doa, ba, ra}, exp_a);
      end
      if (i < 8) got = {got[6:0], wa};
    end
    vectors++;
    if (got !== 8'hC3) begin
      miscompares++;
      $display("FAIL mid_word got=%h exp=c3", got);
    end
  endtask

  task automatic test_random();
    logic aa, ab;
    for (int c = 0; c < 500; c++) begin
      tick(1'b0, c < 460 && $urandom_range(0, 3) != 0, 8'($urandom),
           1'b0 | (c < 460 && $urandom_range(0, 2) == 0), 8'($urandom), aa, ab);
      vectors++;
      if ({wa, sa, doa, ba, ra} !== exp_a) begin
        miscompares++;
        $display("FAIL rand_a cyc=%0d got=%b exp=%b", cyc, {wa, sa, doa, ba, ra}, exp_a);
      end
      vectors++;
      if ({wb, sb, dob, bb, rb} !== exp_b) begin
        miscompares++;
        $display("FAIL rand_b cyc=%0d got=%b exp=%b", cyc, {wb, sb, dob, bb, rb}, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_slow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
